// File: rtl/fusion_frame_scheduler.sv
// fusion_frame_scheduler
//
// Collects the latest LiDAR, camera, radar and IMU samples into per-sensor slots and
// releases one registered 3840-bit fused frame once every slot has been filled.
// A partially filled frame is thrown away when the collection window, counted from
// the first capture of the frame, runs out.
//
// Ports
//   clk, rst                    rising-edge clock, synchronous active-high reset
//   <sensor>_data/_valid/_ready per-sensor sample handshake (lidar, camera, radar, imu)
//   fused_data                  registered fused frame
//                               {lidar, camera, radar, imu, seq[15:0], 48'b0}
//   fused_valid / fused_ready   fused frame handshake
//   frame_drop                  registered one-cycle pulse per discarded frame
//   frame_count / drop_count    saturating counts of emitted / dropped frames
//
// Parameters
//   TIMEOUT_CYCLES  collection window in cycles (2..65535)
//   CNT_W           width of frame_count and drop_count

module fusion_frame_scheduler #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned CNT_W          = 16
) (
  input  logic              clk,
  input  logic              rst,

  input  logic [511:0]      lidar_data,
  input  logic              lidar_valid,
  output logic              lidar_ready,

  input  logic [3071:0]     camera_data,
  input  logic              camera_valid,
  output logic              camera_ready,

  input  logic [127:0]      radar_data,
  input  logic              radar_valid,
  output logic              radar_ready,

  input  logic [63:0]       imu_data,
  input  logic              imu_valid,
  output logic              imu_ready,

  output logic [3839:0]     fused_data,
  output logic              fused_valid,
  input  logic              fused_ready,

  output logic              frame_drop,
  output logic [CNT_W-1:0]  frame_count,
  output logic [CNT_W-1:0]  drop_count
);

  localparam logic [15:0]      TimeoutLast = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntOne      = CNT_W'(1);
  localparam logic [CNT_W-1:0] CntMax      = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    StIdle,
    StCollect,
    StEmit
  } state_e;

  // Slot index order for filled/capture vectors.
  localparam int unsigned SlotLidar  = 0;
  localparam int unsigned SlotCamera = 1;
  localparam int unsigned SlotRadar  = 2;
  localparam int unsigned SlotImu    = 3;

  state_e             state_q, state_d;
  logic [3:0]         filled_q, filled_d;
  logic [15:0]        timer_q, timer_d;
  logic [15:0]        seq_q, seq_d;

  logic [511:0]       lidar_q, lidar_d;
  logic [3071:0]      camera_q, camera_d;
  logic [127:0]       radar_q, radar_d;
  logic [63:0]        imu_q, imu_d;

  logic [3839:0]      fused_data_q, fused_data_d;
  logic               fused_valid_q, fused_valid_d;
  logic               frame_drop_q, frame_drop_d;
  logic [CNT_W-1:0]   frame_count_q, frame_count_d;
  logic [CNT_W-1:0]   drop_count_q, drop_count_d;

  logic               in_ready;
  logic [3:0]         capture;
  logic [3:0]         filled_any;
  logic [3839:0]      fused_word;

  // Readies depend only on registered state, so there is no valid->ready path.
  assign in_ready     = (state_q != StEmit);
  assign lidar_ready  = in_ready;
  assign camera_ready = in_ready;
  assign radar_ready  = in_ready;
  assign imu_ready    = in_ready;

  always_comb begin
    capture             = '0;
    capture[SlotLidar]  = lidar_valid  & in_ready;
    capture[SlotCamera] = camera_valid & in_ready;
    capture[SlotRadar]  = radar_valid  & in_ready;
    capture[SlotImu]    = imu_valid    & in_ready;
  end

  // Newest sample wins: a capture always overwrites the slot.
  always_comb begin
    lidar_d  = capture[SlotLidar]  ? lidar_data  : lidar_q;
    camera_d = capture[SlotCamera] ? camera_data : camera_q;
    radar_d  = capture[SlotRadar]  ? radar_data  : radar_q;
    imu_d    = capture[SlotImu]    ? imu_data    : imu_q;
  end

  // Built from the post-capture slot values so the completing sample lands in the frame.
  assign filled_any = filled_q | capture;
  assign fused_word = {lidar_d, camera_d, radar_d, imu_d, seq_q, 48'h0};

  always_comb begin
    state_d       = state_q;
    filled_d      = filled_any;
    timer_d       = timer_q;
    seq_d         = seq_q;
    fused_data_d  = fused_data_q;
    fused_valid_d = fused_valid_q;
    frame_drop_d  = 1'b0;
    frame_count_d = frame_count_q;
    drop_count_d  = drop_count_q;

    unique case (state_q)
      StIdle: begin
        if (|capture) begin
          timer_d = '0;
          if (&filled_any) begin
            state_d       = StEmit;
            fused_valid_d = 1'b1;
            fused_data_d  = fused_word;
          end else begin
            state_d = StCollect;
          end
        end
      end

      StCollect: begin
        timer_d = timer_q + 16'd1;
        // Completion has priority over the window expiring on the same cycle.
        if (&filled_any) begin
          state_d       = StEmit;
          fused_valid_d = 1'b1;
          fused_data_d  = fused_word;
        end else if (timer_q == TimeoutLast) begin
          state_d      = StIdle;
          filled_d     = '0;
          timer_d      = '0;
          frame_drop_d = 1'b1;
          if (drop_count_q != CntMax) begin
            drop_count_d = drop_count_q + CntOne;
          end
        end
      end

      StEmit: begin
        if (fused_ready) begin
          state_d       = StIdle;
          filled_d      = '0;
          fused_valid_d = 1'b0;
          seq_d         = seq_q + 16'd1;
          if (frame_count_q != CntMax) begin
            frame_count_d = frame_count_q + CntOne;
          end
        end
      end

      default: begin
        state_d       = StIdle;
        filled_d      = '0;
        fused_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      filled_q      <= '0;
      timer_q       <= '0;
      seq_q         <= '0;
      lidar_q       <= '0;
      camera_q      <= '0;
      radar_q       <= '0;
      imu_q         <= '0;
      fused_data_q  <= '0;
      fused_valid_q <= 1'b0;
      frame_drop_q  <= 1'b0;
      frame_count_q <= '0;
      drop_count_q  <= '0;
    end else begin
      state_q       <= state_d;
      filled_q      <= filled_d;
      timer_q       <= timer_d;
      seq_q         <= seq_d;
      lidar_q       <= lidar_d;
      camera_q      <= camera_d;
      radar_q       <= radar_d;
      imu_q         <= imu_d;
      fused_data_q  <= fused_data_d;
      fused_valid_q <= fused_valid_d;
      frame_drop_q  <= frame_drop_d;
      frame_count_q <= frame_count_d;
      drop_count_q  <= drop_count_d;
    end
  end

  assign fused_data  = fused_data_q;
  assign fused_valid = fused_valid_q;
  assign frame_drop  = frame_drop_q;
  assign frame_count = frame_count_q;
  assign drop_count  = drop_count_q;

endmodule

// File: tb/tb_fusion_frame_scheduler.sv
module tb_fusion_frame_scheduler;

  localparam int unsigned Timeout = 8;
  localparam int unsigned CntW    = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic [511:0]     lidar_data;
  logic             lidar_valid;
  logic             lidar_ready;
  logic [3071:0]    camera_data;
  logic             camera_valid;
  logic             camera_ready;
  logic [127:0]     radar_data;
  logic             radar_valid;
  logic             radar_ready;
  logic [63:0]      imu_data;
  logic             imu_valid;
  logic             imu_ready;
  logic [3839:0]    fused_data;
  logic             fused_valid;
  logic             fused_ready;
  logic             frame_drop;
  logic [CntW-1:0]  frame_count;
  logic [CntW-1:0]  drop_count;

  fusion_frame_scheduler #(
    .TIMEOUT_CYCLES (Timeout),
    .CNT_W          (CntW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .lidar_data   (lidar_data),
    .lidar_valid  (lidar_valid),
    .lidar_ready  (lidar_ready),
    .camera_data  (camera_data),
    .camera_valid (camera_valid),
    .camera_ready (camera_ready),
    .radar_data   (radar_data),
    .radar_valid  (radar_valid),
    .radar_ready  (radar_ready),
    .imu_data     (imu_data),
    .imu_valid    (imu_valid),
    .imu_ready    (imu_ready),
    .fused_data   (fused_data),
    .fused_valid  (fused_valid),
    .fused_ready  (fused_ready),
    .frame_drop   (frame_drop),
    .frame_count  (frame_count),
    .drop_count   (drop_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  logic [15:0]     exp_seq;
  logic [CntW-1:0] exp_frames;
  logic [CntW-1:0] exp_drops;
  logic [3839:0]   exp_word;
  logic [511:0]    lidar_a;

  function automatic logic [3839:0] make_word(input logic [511:0] l, input logic [3071:0] c,
                                             input logic [127:0] r, input logic [63:0] i,
                                             input logic [15:0] s);
    return {l, c, r, i, s, 48'h0};
  endfunction

  // Distinct per-sensor patterns derived from k.
  task automatic set_data(input int k);
    logic [31:0] w;
    w           = 32'hA500_0000 ^ 32'(k * 32'h0001_0203);
    lidar_data  = {16{w}};
    camera_data = {96{w ^ 32'h0C0C_3C3C}};
    radar_data  = {4{w ^ 32'h00F0_0F00}};
    imu_data    = {2{w ^ 32'h1234_5678}};
  endtask

  // v = {imu, radar, camera, lidar}
  task automatic drive(input logic [3:0] v);
    lidar_valid  = v[0];
    camera_valid = v[1];
    radar_valid  = v[2];
    imu_valid    = v[3];
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic transfer();
    fused_ready = 1'b1;
    step();
    fused_ready = 1'b0;
  endtask

  function automatic logic [3:0] readies();
    return {imu_ready, radar_ready, camera_ready, lidar_ready};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    checks++;
    if (fused_valid !== 1'b0) begin
      fails++; $display("FAIL reset_valid: got %b want 0", fused_valid);
    end
    checks++;
    if (fused_data !== '0) begin
      fails++; $display("FAIL reset_data: got hi=%h want 0", fused_data[3839:3776]);
    end
    checks++;
    if (frame_drop !== 1'b0 || frame_count !== '0 || drop_count !== '0) begin
      fails++;
      $display("FAIL reset_counters: got drop=%b fc=%0d dc=%0d want 0 0 0",
               frame_drop, frame_count, drop_count);
    end
    checks++;
    if (readies() !== 4'b1111) begin
      fails++; $display("FAIL reset_ready: got %b want 1111", readies());
    end
  endtask

  task automatic test_timeout();
    set_data(1);
    drive(4'b0100);
    step();
    drive(4'b0000);
    for (int k = 1; k <= int'(Timeout); k++) begin
      step();
      checks++;
      if (frame_drop !== (k == int'(Timeout))) begin
        fails++; $display("FAIL timeout_pulse_k%0d: got %b want %b", k, frame_drop,
                          (k == int'(Timeout)));
      end
      checks++;
      if (fused_valid !== 1'b0 || readies() !== 4'b1111) begin
        fails++; $display("FAIL timeout_state_k%0d: got valid=%b rdy=%b want 0 1111", k,
                          fused_valid, readies());
      end
    end
    exp_drops++;
    checks++;
    if (drop_count !== exp_drops) begin
      fails++; $display("FAIL timeout_drop_count: got %0d want %0d", drop_count, exp_drops);
    end
    step();
    checks++;
    if (frame_drop !== 1'b0) begin
      fails++; $display("FAIL timeout_single_pulse: got %b want 0", frame_drop);
    end
    // Next full frame still carries seq 0.
    set_data(2);
    drive(4'b1111);
    step();
    drive(4'b0000);
    exp_word = make_word(lidar_data, camera_data, radar_data, imu_data, exp_seq);
    checks++;
    if (fused_valid !== 1'b1 || fused_data !== exp_word) begin
      fails++; $display("FAIL timeout_next_frame: got valid=%b seq=%h want 1 %h", fused_valid,
                        fused_data[63:48], exp_seq);
    end
    transfer();
    exp_seq++;
    exp_frames++;
  endtask

  task automatic test_all_four();
    set_data(3);
    drive(4'b1111);
    step();
    drive(4'b0000);
    exp_word = make_word(lidar_data, camera_data, radar_data, imu_data, exp_seq);
    checks++;
    if (fused_valid !== 1'b1) begin
      fails++; $display("FAIL all4_valid: got %b want 1", fused_valid);
    end
    checks++;
    if (fused_data !== exp_word) begin
      fails++; $display("FAIL all4_data: got hi=%h lo=%h want hi=%h lo=%h",
                        fused_data[3839:3712], fused_data[127:0], exp_word[3839:3712],
                        exp_word[127:0]);
    end
    checks++;
    if (fused_data[3327:3296] !== camera_data[3071:3040] ||
        fused_data[255:128] !== radar_data || fused_data[127:64] !== imu_data) begin
      fails++; $display("FAIL all4_fields: got radar=%h imu=%h want %h %h",
                        fused_data[255:128], fused_data[127:64], radar_data, imu_data);
    end
    checks++;
    if (fused_data[63:48] !== exp_seq || fused_data[47:0] !== 48'h0) begin
      fails++; $display("FAIL all4_seq: got %h/%h want %h/0", fused_data[63:48],
                        fused_data[47:0], exp_seq);
    end
    checks++;
    if (readies() !== 4'b0000) begin
      fails++; $display("FAIL all4_ready_emit: got %b want 0000", readies());
    end
    transfer();
    exp_seq++;
    exp_frames++;
    checks++;
    if (fused_valid !== 1'b0 || frame_count !== exp_frames || readies() !== 4'b1111) begin
      fails++; $display("FAIL all4_after: got valid=%b fc=%0d rdy=%b want 0 %0d 1111",
                        fused_valid, frame_count, exp_frames, readies());
    end
  endtask

  task automatic test_overwrite();
    set_data(4);
    lidar_a = lidar_data;
    drive(4'b0001);
    step();
    drive(4'b0000);
    step();
    set_data(5);
    drive(4'b0001);
    step();
    drive(4'b1110);
    step();
    drive(4'b0000);
    exp_word = make_word(lidar_data, camera_data, radar_data, imu_data, exp_seq);
    checks++;
    if (fused_valid !== 1'b1 || fused_data !== exp_word) begin
      fails++; $display("FAIL overwrite_frame: got valid=%b lidar=%h want 1 %h", fused_valid,
                        fused_data[3839:3808], lidar_data[511:480]);
    end
    checks++;
    if (fused_data[3839:3328] === lidar_a) begin
      fails++; $display("FAIL overwrite_old_sample: got %h want %h", fused_data[3839:3808],
                        lidar_data[511:480]);
    end
    transfer();
    exp_seq++;
    exp_frames++;
  endtask

  task automatic test_backpressure();
    set_data(6);
    drive(4'b1111);
    step();
    exp_word = make_word(lidar_data, camera_data, radar_data, imu_data, exp_seq);
    // Offer fresh samples during the stall; they must not be taken.
    set_data(7);
    for (int k = 0; k < 10; k++) begin
      step();
      checks++;
      if (fused_valid !== 1'b1 || readies() !== 4'b0000 || fused_data !== exp_word) begin
        fails++; $display("FAIL stall_k%0d: got valid=%b rdy=%b seq=%h want 1 0000 %h", k,
                          fused_valid, readies(), fused_data[63:48], exp_seq);
      end
    end
    drive(4'b0000);
    transfer();
    exp_seq++;
    exp_frames++;
    checks++;
    if (fused_valid !== 1'b0 || readies() !== 4'b1111 || frame_count !== exp_frames) begin
      fails++; $display("FAIL stall_release: got valid=%b rdy=%b fc=%0d want 0 1111 %0d",
                        fused_valid, readies(), frame_count, exp_frames);
    end
    step();
    checks++;
    if (fused_valid !== 1'b0) begin
      fails++; $display("FAIL stall_no_phantom: got %b want 0", fused_valid);
    end
  endtask

  task automatic test_complete_on_timeout();
    set_data(8);
    drive(4'b0100);
    step();
    drive(4'b0000);
    for (int k = 1; k < int'(Timeout); k++) begin
      step();
      checks++;
      if (frame_drop !== 1'b0 || fused_valid !== 1'b0) begin
        fails++; $display("FAIL edge_wait_k%0d: got drop=%b valid=%b want 0 0", k, frame_drop,
                          fused_valid);
      end
    end
    drive(4'b1011);
    step();
    drive(4'b0000);
    exp_word = make_word(lidar_data, camera_data, radar_data, imu_data, exp_seq);
    checks++;
    if (fused_valid !== 1'b1 || frame_drop !== 1'b0 || drop_count !== exp_drops) begin
      fails++; $display("FAIL edge_complete: got valid=%b drop=%b dc=%0d want 1 0 %0d",
                        fused_valid, frame_drop, drop_count, exp_drops);
    end
    checks++;
    if (fused_data !== exp_word) begin
      fails++; $display("FAIL edge_data: got seq=%h lidar=%h want %h %h", fused_data[63:48],
                        fused_data[3839:3808], exp_seq, lidar_data[511:480]);
    end
    transfer();
    exp_seq++;
    exp_frames++;
  endtask

  task automatic test_back_to_back();
    fused_ready = 1'b1;
    set_data(9);
    drive(4'b1111);
    step();
    checks++;
    if (fused_valid !== 1'b1 || readies() !== 4'b0000) begin
      fails++; $display("FAIL b2b_emit1: got valid=%b rdy=%b want 1 0000", fused_valid,
                        readies());
    end
    step();
    exp_seq++;
    exp_frames++;
    checks++;
    if (fused_valid !== 1'b0 || readies() !== 4'b1111 || frame_count !== exp_frames) begin
      fails++; $display("FAIL b2b_xfer1: got valid=%b rdy=%b fc=%0d want 0 1111 %0d",
                        fused_valid, readies(), frame_count, exp_frames);
    end
    step();
    exp_word = make_word(lidar_data, camera_data, radar_data, imu_data, exp_seq);
    checks++;
    if (fused_valid !== 1'b1 || fused_data !== exp_word) begin
      fails++; $display("FAIL b2b_emit2: got valid=%b seq=%h want 1 %h", fused_valid,
                        fused_data[63:48], exp_seq);
    end
    step();
    drive(4'b0000);
    fused_ready = 1'b0;
    exp_seq++;
    exp_frames++;
    checks++;
    if (fused_valid !== 1'b0 || frame_count !== exp_frames) begin
      fails++; $display("FAIL b2b_xfer2: got valid=%b fc=%0d want 0 %0d", fused_valid,
                        frame_count, exp_frames);
    end
  endtask

  task automatic test_reset_in_emit();
    set_data(10);
    drive(4'b1111);
    step();
    drive(4'b0000);
    checks++;
    if (fused_valid !== 1'b1) begin
      fails++; $display("FAIL rst_emit_pre: got %b want 1", fused_valid);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_seq    = '0;
    exp_frames = '0;
    exp_drops  = '0;
    checks++;
    if (fused_valid !== 1'b0 || frame_count !== '0 || drop_count !== '0 ||
        fused_data !== '0 || readies() !== 4'b1111) begin
      fails++; $display("FAIL rst_emit_clear: got valid=%b fc=%0d dc=%0d rdy=%b want 0 0 0 1111",
                        fused_valid, frame_count, drop_count, readies());
    end
    set_data(11);
    drive(4'b1111);
    step();
    drive(4'b0000);
    exp_word = make_word(lidar_data, camera_data, radar_data, imu_data, exp_seq);
    checks++;
    if (fused_valid !== 1'b1 || fused_data !== exp_word) begin
      fails++; $display("FAIL rst_emit_next: got valid=%b seq=%h want 1 %h", fused_valid,
                        fused_data[63:48], exp_seq);
    end
    transfer();
    exp_frames++;
    checks++;
    if (frame_count !== exp_frames) begin
      fails++; $display("FAIL rst_emit_count: got %0d want %0d", frame_count, exp_frames);
    end
  endtask

  initial begin
    rst         = 1'b1;
    fused_ready = 1'b0;
    drive(4'b0000);
    set_data(0);
    exp_seq    = '0;
    exp_frames = '0;
    exp_drops  = '0;
    test_reset();
    test_timeout();
    test_all_four();
    test_overwrite();
    test_backpressure();
    test_complete_on_timeout();
    test_back_to_back();
    test_reset_in_emit();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
